// File: rtl/me_pkg.sv
// Shared types and widths for the HEXBS motion-estimation frame scheduler.
package me_pkg;

  localparam int MV_W        = 6;
  localparam int SAD_W       = 16;
  localparam int ADDR_W      = 12;
  localparam int CFG_W       = 7;
  localparam int MB_SIZE_DEF = 16;

  localparam logic [SAD_W-1:0] SAD_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_EMIT    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_DONE    = 3'd5
  } me_state_e;

endpackage

// File: rtl/mb_raster_counter.sv
// Raster-order macroblock position: x/y plus a running linear index, one step per advance.
// Latency: registered, updates the cycle after clr_i/adv_i; last_o is combinational on current position.
module mb_raster_counter
  import me_pkg::*;
#(
  parameter int IDXW = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [CFG_W-1:0] cfg_w_i,
  input  logic [CFG_W-1:0] cfg_h_i,
  output logic [CFG_W-1:0] mb_x_o,
  output logic [CFG_W-1:0] mb_y_o,
  output logic [IDXW-1:0]  mb_idx_o,
  output logic             last_o
);

  logic [CFG_W-1:0] mb_x_q, mb_x_d;
  logic [CFG_W-1:0] mb_y_q, mb_y_d;
  logic [IDXW-1:0]  mb_idx_q, mb_idx_d;
  logic             x_end;
  logic             y_end;

  assign x_end = (mb_x_q == cfg_w_i - CFG_W'(1));
  assign y_end = (mb_y_q == cfg_h_i - CFG_W'(1));

  always_comb begin
    mb_x_d   = mb_x_q;
    mb_y_d   = mb_y_q;
    mb_idx_d = mb_idx_q;
    if (clr_i) begin
      mb_x_d   = '0;
      mb_y_d   = '0;
      mb_idx_d = '0;
    end else if (adv_i) begin
      // Linear index tracks raster order directly, so no y*w multiply is needed.
      mb_idx_d = mb_idx_q + IDXW'(1);
      if (x_end) begin
        mb_x_d = '0;
        mb_y_d = mb_y_q + CFG_W'(1);
      end else begin
        mb_x_d = mb_x_q + CFG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mb_x_q   <= '0;
      mb_y_q   <= '0;
      mb_idx_q <= '0;
    end else begin
      mb_x_q   <= mb_x_d;
      mb_y_q   <= mb_y_d;
      mb_idx_q <= mb_idx_d;
    end
  end

  assign mb_x_o   = mb_x_q;
  assign mb_y_o   = mb_y_q;
  assign mb_idx_o = mb_idx_q;
  assign last_o   = x_end && y_end;

endmodule

// File: rtl/me_mb_scheduler.sv
// Walks a frame's MBs in raster order, drives the ME start/done handshake, streams MV+SAD results; ME_TIMEOUT_EN adds a WAIT watchdog.
// Latency: frame_start->me_start 1 cycle, me_done->res_valid 1 cycle, result handshake->next me_start 2 cycles.
// Backpressure: result payload held while res_ready is low; only i_abort may retract res_valid.
module me_mb_scheduler
  import me_pkg::*;
#(
  parameter int MB_SIZE     = MB_SIZE_DEF,
  parameter int MAX_MB_W    = 120,
  parameter int MAX_MB_H    = 68,
  parameter int IDXW        = 13,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_frame_start,
  input  logic                    i_abort,
  input  logic [CFG_W-1:0]        i_cfg_mb_w,
  input  logic [CFG_W-1:0]        i_cfg_mb_h,
  output logic                    o_me_start,
  output logic [ADDR_W-1:0]       o_mb_px_x,
  output logic [ADDR_W-1:0]       o_mb_px_y,
  input  logic                    i_me_done,
  input  logic signed [MV_W-1:0]  i_me_mv_x,
  input  logic signed [MV_W-1:0]  i_me_mv_y,
  input  logic [SAD_W-1:0]        i_me_sad,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [IDXW-1:0]         o_res_mb_idx,
  output logic signed [MV_W-1:0]  o_res_mv_x,
  output logic signed [MV_W-1:0]  o_res_mv_y,
  output logic [SAD_W-1:0]        o_res_sad,
  output logic                    o_busy,
  output logic                    o_frame_done
`ifdef ME_TIMEOUT_EN
  ,
  output logic                    o_timeout
`endif
);

  localparam int               PX_SH   = $clog2(MB_SIZE);
  localparam logic [CFG_W-1:0] MAX_W_C = CFG_W'(MAX_MB_W);
  localparam logic [CFG_W-1:0] MAX_H_C = CFG_W'(MAX_MB_H);

  me_state_e state_q, state_d;

  logic [CFG_W-1:0]       cfg_w_q, cfg_h_q;
  logic [IDXW-1:0]        res_idx_q;
  logic signed [MV_W-1:0] res_mv_x_q, res_mv_y_q;
  logic [SAD_W-1:0]       res_sad_q;

  logic [CFG_W-1:0] mb_x, mb_y;
  logic [IDXW-1:0]  mb_idx;
  logic             mb_last;
  logic             start_acc;
  logic             cfg_zero;
  logic             wait_expired;
  logic             capture_go;

  assign start_acc  = (state_q == ST_IDLE) && i_frame_start && !i_abort;
  assign cfg_zero   = (i_cfg_mb_w == '0) || (i_cfg_mb_h == '0);
  assign capture_go = (state_q == ST_WAIT) && !i_abort && (i_me_done || wait_expired);

  mb_raster_counter #(
    .IDXW(IDXW)
  ) u_raster (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (start_acc),
    .adv_i    (state_q == ST_ADVANCE),
    .cfg_w_i  (cfg_w_q),
    .cfg_h_i  (cfg_h_q),
    .mb_x_o   (mb_x),
    .mb_y_o   (mb_y),
    .mb_idx_o (mb_idx),
    .last_o   (mb_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Abort overrides every other event, including a simultaneous frame start.
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (i_frame_start) state_d = cfg_zero ? ST_DONE : ST_LAUNCH;
        ST_LAUNCH:  state_d = ST_WAIT;
        ST_WAIT:    if (i_me_done || wait_expired) state_d = ST_EMIT;
        ST_EMIT:    if (i_res_ready) state_d = ST_ADVANCE;
        ST_ADVANCE: state_d = mb_last ? ST_DONE : ST_LAUNCH;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_me_start   = 1'b0;
    o_res_valid  = 1'b0;
    o_frame_done = 1'b0;
    o_busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_LAUNCH: o_me_start   = 1'b1;
      ST_EMIT:   o_res_valid  = !i_abort;
      ST_DONE:   o_frame_done = !i_abort;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_w_q    <= '0;
      cfg_h_q    <= '0;
      res_idx_q  <= '0;
      res_mv_x_q <= '0;
      res_mv_y_q <= '0;
      res_sad_q  <= '0;
    end else begin
      if (start_acc) begin
        cfg_w_q <= (i_cfg_mb_w > MAX_W_C) ? MAX_W_C : i_cfg_mb_w;
        cfg_h_q <= (i_cfg_mb_h > MAX_H_C) ? MAX_H_C : i_cfg_mb_h;
      end
      if (capture_go) begin
        res_idx_q <= mb_idx;
        if (i_me_done) begin
          res_mv_x_q <= i_me_mv_x;
          res_mv_y_q <= i_me_mv_y;
          res_sad_q  <= i_me_sad;
        end else begin
          res_mv_x_q <= '0;
          res_mv_y_q <= '0;
          res_sad_q  <= SAD_MAX;
        end
      end
    end
  end

`ifdef ME_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic [TCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           timeout_q, timeout_d;

  assign wait_expired = (state_q == ST_WAIT) && (wait_cnt_q == TCW'(TIMEOUT_CYC - 1));

  always_comb begin
    wait_cnt_d = (state_q == ST_WAIT) ? wait_cnt_q + TCW'(1) : '0;
    timeout_d  = timeout_q;
    if (start_acc)                     timeout_d = 1'b0;
    else if (capture_go && !i_me_done) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign wait_expired = 1'b0;
`endif

  assign o_mb_px_x    = ADDR_W'(mb_x) << PX_SH;
  assign o_mb_px_y    = ADDR_W'(mb_y) << PX_SH;
  assign o_res_mb_idx = res_idx_q;
  assign o_res_mv_x   = res_mv_x_q;
  assign o_res_mv_y   = res_mv_y_q;
  assign o_res_sad    = res_sad_q;

endmodule

// File: tb/tb_me_mb_scheduler.sv
// Bench for me_mb_scheduler: engine model answers start pulses, scoreboard checks every accepted result.
module tb_me_mb_scheduler;

  typedef struct {
    int          idx;
    logic [5:0]  mvx;
    logic [5:0]  mvy;
    logic [15:0] sad;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_frame_start;
  logic        i_abort;
  logic [6:0]  i_cfg_mb_w;
  logic [6:0]  i_cfg_mb_h;
  logic        o_me_start;
  logic [11:0] o_mb_px_x;
  logic [11:0] o_mb_px_y;
  logic        i_me_done;
  logic [5:0]  i_me_mv_x;
  logic [5:0]  i_me_mv_y;
  logic [15:0] i_me_sad;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [12:0] o_res_mb_idx;
  logic [5:0]  o_res_mv_x;
  logic [5:0]  o_res_mv_y;
  logic [15:0] o_res_sad;
  logic        o_busy;
  logic        o_frame_done;
`ifdef ME_TIMEOUT_EN
  logic        o_timeout;
`endif

  me_mb_scheduler #(
    .MB_SIZE(16), .MAX_MB_W(120), .MAX_MB_H(68), .IDXW(13), .TIMEOUT_CYC(20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_start(i_frame_start),
    .i_abort      (i_abort),
    .i_cfg_mb_w   (i_cfg_mb_w),
    .i_cfg_mb_h   (i_cfg_mb_h),
    .o_me_start   (o_me_start),
    .o_mb_px_x    (o_mb_px_x),
    .o_mb_px_y    (o_mb_px_y),
    .i_me_done    (i_me_done),
    .i_me_mv_x    (i_me_mv_x),
    .i_me_mv_y    (i_me_mv_y),
    .i_me_sad     (i_me_sad),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_mb_idx (o_res_mb_idx),
    .o_res_mv_x   (o_res_mv_x),
    .o_res_mv_y   (o_res_mv_y),
    .o_res_sad    (o_res_sad),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
`ifdef ME_TIMEOUT_EN
    ,
    .o_timeout    (o_timeout)
`endif
  );

  int   tests = 0;
  int   fails = 0;
  int   n_start, n_res, n_fdone, launch_cnt, tb_w;
  int   eng_cnt = 0;
  int   eng_delay = 5;
  int   cur_idx = 0;
  bit   eng_never = 0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model plus result monitor, all sampled on the falling edge.
  initial begin : monitor
    exp_t        e;
    logic        pv_stall;
    logic        pv_abort;
    logic [12:0] pv_idx;
    logic [5:0]  pv_mx, pv_my;
    logic [15:0] pv_sad;
    int          ex, ey;
    pv_stall = 1'b0;
    pv_abort = 1'b0;
    pv_idx = '0; pv_mx = '0; pv_my = '0; pv_sad = '0;
    forever begin
      @(negedge clk);
      if (i_me_done === 1'b1) begin
        tests++;
        if (o_res_valid !== 1'b1) begin
          fails++;
          $display("FAIL done_to_valid: res_valid=%b one cycle after done, required 1", o_res_valid);
        end
      end
      i_me_done = 1'b0;
      if (pv_stall && !pv_abort) begin
        tests++;
        if (o_res_valid !== 1'b1 || o_res_mb_idx !== pv_idx || o_res_mv_x !== pv_mx ||
            o_res_mv_y !== pv_my || o_res_sad !== pv_sad) begin
          fails++;
          $display("FAIL stall_hold: valid=%b idx=%0d sad=%h, required valid=1 idx=%0d sad=%h",
                   o_res_valid, o_res_mb_idx, o_res_sad, pv_idx, pv_sad);
        end
      end
      if (o_res_valid === 1'b1 && i_res_ready === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_empty: result idx=%0d arrived, required none", o_res_mb_idx);
        end else begin
          e = sb.pop_front();
          if (o_res_mb_idx !== 13'(e.idx) || o_res_mv_x !== e.mvx || o_res_mv_y !== e.mvy ||
              o_res_sad !== e.sad) begin
            fails++;
            $display("FAIL result: got idx=%0d mv=(%0d,%0d) sad=%h, required idx=%0d mv=(%0d,%0d) sad=%h",
                     o_res_mb_idx, $signed(o_res_mv_x), $signed(o_res_mv_y), o_res_sad,
                     e.idx, $signed(e.mvx), $signed(e.mvy), e.sad);
          end
        end
        n_res++;
      end
      pv_stall = (o_res_valid === 1'b1) && (i_res_ready !== 1'b1);
      pv_abort = (i_abort === 1'b1);
      pv_idx = o_res_mb_idx; pv_mx = o_res_mv_x; pv_my = o_res_mv_y; pv_sad = o_res_sad;
      if (o_frame_done === 1'b1) n_fdone++;
      if (i_abort === 1'b1) begin
        eng_cnt = 0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          e.idx = cur_idx;
          e.mvx = 6'($urandom);
          e.mvy = 6'($urandom);
          e.sad = 16'($urandom);
          i_me_mv_x = e.mvx;
          i_me_mv_y = e.mvy;
          i_me_sad  = e.sad;
          i_me_done = 1'b1;
          sb.push_back(e);
        end
      end
      if (o_me_start === 1'b1) begin
        ex = launch_cnt % tb_w;
        ey = launch_cnt / tb_w;
        tests++;
        if (o_mb_px_x !== 12'(ex * 16) || o_mb_px_y !== 12'(ey * 16)) begin
          fails++;
          $display("FAIL px_origin: got (%0d,%0d), required (%0d,%0d)",
                   o_mb_px_x, o_mb_px_y, ex * 16, ey * 16);
        end
        cur_idx = launch_cnt;
        launch_cnt++;
        n_start++;
        if (eng_never) begin
          e.idx = cur_idx; e.mvx = '0; e.mvy = '0; e.sad = 16'hFFFF;
          sb.push_back(e);
          eng_cnt = 0;
        end else begin
          eng_cnt = eng_delay;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_model(input int w);
    sb.delete();
    launch_cnt = 0;
    tb_w       = w;
    n_start    = 0;
    n_res      = 0;
    n_fdone    = 0;
  endtask

  task automatic start_frame(input int w, input int h);
    tick();
    i_cfg_mb_w    = 7'(w);
    i_cfg_mb_h    = 7'(h);
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    i_cfg_mb_w    = 7'd0;
    i_cfg_mb_h    = 7'd0;
  endtask

  task automatic wait_fdone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    tests++;
    if (o_me_start !== 1'b0 || o_res_valid !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: start=%b valid=%b busy=%b fdone=%b, required all 0",
               o_me_start, o_res_valid, o_busy, o_frame_done);
    end
    tests++;
    if (o_res_mb_idx !== '0 || o_res_mv_x !== '0 || o_res_mv_y !== '0 || o_res_sad !== '0 ||
        o_mb_px_x !== '0 || o_mb_px_y !== '0) begin
      fails++;
      $display("FAIL reset_data: idx=%0d sad=%h px=(%0d,%0d), required all 0",
               o_res_mb_idx, o_res_sad, o_mb_px_x, o_mb_px_y);
    end
`ifdef ME_TIMEOUT_EN
    tests++;
    if (o_timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_timeout: got %b, required 0", o_timeout);
    end
`endif
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_raster_2x2();
    bit ok;
    reset_model(2);
    i_res_ready = 1'b1;
    start_frame(2, 2);
    @(negedge clk);
    tests++;
    if (o_me_start !== 1'b1 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL start_latency: start=%b busy=%b one cycle after frame_start, required 1/1",
               o_me_start, o_busy);
    end
    wait_fdone(300, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL raster_fdone: frame_done not seen in 300 cycles, required 1 pulse"); end
    tests++;
    if (n_res != 4 || n_start != 4 || n_fdone != 1 || sb.size() != 0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL raster_counts: res=%0d starts=%0d fdone=%0d left=%0d busy=%b, required 4/4/1/0/0",
               n_res, n_start, n_fdone, sb.size(), o_busy);
    end
  endtask

  task automatic test_backpressure();
    bit          seen;
    bit          ok;
    logic [12:0] s_idx;
    logic [15:0] s_sad;
    reset_model(2);
    tick();
    i_res_ready = 1'b0;
    start_frame(2, 1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_res_valid === 1'b1) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL bp_valid: res_valid not seen in 50 cycles, required 1"); end
    s_idx = o_res_mb_idx;
    s_sad = o_res_sad;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (o_res_valid !== 1'b1 || o_res_mb_idx !== s_idx || o_res_sad !== s_sad || o_me_start !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold: cyc %0d valid=%b idx=%0d sad=%h start=%b, required 1/%0d/%h/0",
                 i, o_res_valid, o_res_mb_idx, o_res_sad, o_me_start, s_idx, s_sad);
      end
    end
    tick();
    i_res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (o_me_start !== 1'b0 || o_res_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_advance: start=%b valid=%b one cycle after handshake, required 0/0",
               o_me_start, o_res_valid);
    end
    @(negedge clk);
    tests++;
    if (o_me_start !== 1'b1) begin
      fails++;
      $display("FAIL bp_relaunch: start=%b two cycles after handshake, required 1", o_me_start);
    end
    wait_fdone(200, ok);
    tests++;
    if (!ok || n_res != 2 || n_fdone != 1) begin
      fails++;
      $display("FAIL bp_counts: ok=%b res=%0d fdone=%0d, required 1/2/1", ok, n_res, n_fdone);
    end
  endtask

  task automatic test_zero_cfg();
    int pulses;
    reset_model(1);
    start_frame(0, 5);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_frame_done === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 1 || n_start != 0 || n_res != 0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_cfg: fdone=%0d starts=%0d res=%0d busy=%b, required 1/0/0/0",
               pulses, n_start, n_res, o_busy);
    end
  endtask

  task automatic test_abort();
    bit seen;
    bit ok;
    int pulses;
    reset_model(4);
    i_res_ready = 1'b1;
    start_frame(4, 1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_start == 3) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL abort_reach: MB 3 not launched in 200 cycles, required launch"); end
    tick();
    i_abort       = 1'b1;
    i_frame_start = 1'b1;
    tick();
    i_abort       = 1'b0;
    i_frame_start = 1'b0;
    @(negedge clk);
    tests++;
    if (o_busy !== 1'b0 || o_res_valid !== 1'b0 || o_me_start !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b valid=%b start=%b after abort, required 0/0/0",
               o_busy, o_res_valid, o_me_start);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_frame_done === 1'b1 || o_me_start === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || n_res != 2) begin
      fails++;
      $display("FAIL abort_quiet: fdone/start pulses=%0d res=%0d, required 0/2", pulses, n_res);
    end
    reset_model(2);
    start_frame(2, 1);
    wait_fdone(200, ok);
    tests++;
    if (!ok || n_res != 2 || n_fdone != 1 || sb.size() != 0) begin
      fails++;
      $display("FAIL abort_restart: ok=%b res=%0d fdone=%0d left=%0d, required 1/2/1/0",
               ok, n_res, n_fdone, sb.size());
    end
  endtask

  task automatic test_midframe_start();
    bit seen;
    bit ok;
    reset_model(3);
    i_res_ready = 1'b1;
    start_frame(3, 1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_res >= 1) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL mid_first: no result in 100 cycles, required 1"); end
    start_frame(1, 1);
    wait_fdone(300, ok);
    tests++;
    if (!ok || n_res != 3 || n_start != 3 || n_fdone != 1 || sb.size() != 0) begin
      fails++;
      $display("FAIL mid_start: ok=%b res=%0d starts=%0d fdone=%0d left=%0d, required 1/3/3/1/0",
               ok, n_res, n_start, n_fdone, sb.size());
    end
  endtask

`ifdef ME_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    reset_model(2);
    i_res_ready = 1'b1;
    eng_never   = 1'b1;
    start_frame(2, 1);
    wait_fdone(300, ok);
    eng_never = 1'b0;
    tests++;
    if (!ok || n_res != 2 || n_start != 2 || sb.size() != 0) begin
      fails++;
      $display("FAIL timeout_flow: ok=%b res=%0d starts=%0d left=%0d, required 1/2/2/0",
               ok, n_res, n_start, sb.size());
    end
    tests++;
    if (o_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_flag: got %b, required 1", o_timeout);
    end
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    i_frame_start = 1'b0;
    i_abort       = 1'b0;
    i_cfg_mb_w    = 7'd0;
    i_cfg_mb_h    = 7'd0;
    i_me_done     = 1'b0;
    i_me_mv_x     = 6'd0;
    i_me_mv_y     = 6'd0;
    i_me_sad      = 16'd0;
    i_res_ready   = 1'b1;
    tb_w          = 1;
    test_reset();
    test_raster_2x2();
    test_backpressure();
    test_zero_cfg();
    test_abort();
    test_midframe_start();
`ifdef ME_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
